apb3_completer_regs: RTL and testbench

APB3 completer holding a bank of 32-bit read/write registers, with address decode, error response and optional wait-state insertion. It sits directly downstream of the two-to-one APB3 requester multiplexer and terminates that multiplexer's output bus. It is also the origin of `presetn` for the whole APB3 segment.

---
 rtl/renode_apb3_if.sv | 26 ++
 rtl/apb3_completer_regs.sv | 139 +++++++++++++
 tb/tb_apb3_completer_regs.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/renode_apb3_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
// The completer also originates presetn for the segment.
interface renode_apb3_if #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32
);
    logic [AddrW-1:0] paddr;
    logic             pselx;
    logic             penable;
    logic             pwrite;
    logic [DataW-1:0] pwdata;
    logic [DataW-1:0] prdata;
    logic             pready;
    logic             pslverr;
    logic             presetn;

    modport master (
        output paddr, pselx, penable, pwrite, pwdata,
        input  prdata, pready, pslverr, presetn
    );

    modport slave (
        input  paddr, pselx, penable, pwrite, pwdata,
        output prdata, pready, pslverr, presetn
    );
endinterface

// File: rtl/apb3_completer_regs.sv
// APB3 completer with a bank of 32-bit registers, decode/error response and
// optional wait states (compile-time macro APB3_COMPLETER_WAIT_EN).
module apb3_completer_regs #(
    parameter int unsigned AddressWidth = 20,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegCount     = 16,
    parameter logic [31:0] ResetValue   = 32'h0,
    parameter int unsigned WaitCycles   = 2
) (
    input  logic                clk,
    input  logic                rst,
    renode_apb3_if.slave        apb3,
    output logic [1:0]          dbg_state
);
    localparam int unsigned IdxW = (RegCount > 1) ? $clog2(RegCount) : 1;

    // Handshake: a transfer starts on an edge with pselx=1/penable=0 in IDLE,
    // and completes on the edge where pselx, penable and pready are all high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef APB3_COMPLETER_WAIT_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            rst_q;
    logic [31:0]     regs [RegCount];
    logic            lat_legal;
    logic            lat_write;
    logic [31:0]     lat_wdata;
    logic [IdxW-1:0] lat_idx;
`ifdef APB3_COMPLETER_WAIT_EN
    logic [3:0]      wait_cnt;
    logic [31:0]     lat_rdata;
`endif

    logic [31:0]     index_ext;
    logic [IdxW-1:0] idx;
    logic            legal;
    logic            setup;
    logic [31:0]     rdata;
    logic            unused_ok;

    assign index_ext = 32'(apb3.paddr[AddressWidth-1:2]);
    assign idx       = index_ext[IdxW-1:0];
    assign legal     = (apb3.paddr[1:0] == 2'b00) && (index_ext < RegCount);
    assign setup     = apb3.pselx & ~apb3.penable;
    assign rdata     = legal ? regs[idx] : 32'h0;
    assign unused_ok = ^{apb3.paddr, 32'(DataWidth), 32'(WaitCycles)};

    assign apb3.presetn = ~rst_q;
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state        <= IDLE;
            apb3.pready  <= 1'b0;
            apb3.pslverr <= 1'b0;
            apb3.prdata  <= 32'h0;
            lat_legal    <= 1'b0;
            lat_write    <= 1'b0;
            lat_wdata    <= 32'h0;
            lat_idx      <= '0;
`ifdef APB3_COMPLETER_WAIT_EN
            wait_cnt     <= 4'd0;
            lat_rdata    <= 32'h0;
`endif
            for (int i = 0; i < int'(RegCount); i++) begin
                regs[i] <= ResetValue;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        lat_legal <= legal;
                        lat_write <= apb3.pwrite;
                        lat_wdata <= apb3.pwdata;
                        lat_idx   <= idx;
`ifdef APB3_COMPLETER_WAIT_EN
                        wait_cnt  <= 4'(WaitCycles);
                        if (WaitCycles == 0) begin
                            state        <= RESP;
                            apb3.pready  <= 1'b1;
                            apb3.pslverr <= ~legal;
                            apb3.prdata  <= rdata;
                        end else begin
                            state     <= WAIT;
                            lat_rdata <= rdata;
                        end
`else
                        state        <= RESP;
                        apb3.pready  <= 1'b1;
                        apb3.pslverr <= ~legal;
                        apb3.prdata  <= rdata;
`endif
                    end
                end
`ifdef APB3_COMPLETER_WAIT_EN
                WAIT: begin
                    if (!apb3.pselx) begin
                        state <= IDLE;
                    end else if (apb3.penable) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        // Read data was captured at the setup edge.
                        if (wait_cnt == 4'd1) begin
                            state        <= RESP;
                            apb3.pready  <= 1'b1;
                            apb3.pslverr <= ~lat_legal;
                            apb3.prdata  <= lat_rdata;
                        end
                    end
                end
`endif
                RESP: begin
                    if (!apb3.pselx) begin
                        state        <= IDLE;
                        apb3.pready  <= 1'b0;
                        apb3.pslverr <= 1'b0;
                        apb3.prdata  <= 32'h0;
                    end else if (apb3.penable) begin
                        if (lat_legal && lat_write) begin
                            regs[lat_idx] <= lat_wdata;
                        end
                        state        <= IDLE;
                        apb3.pready  <= 1'b0;
                        apb3.pslverr <= 1'b0;
                        apb3.prdata  <= 32'h0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_completer_regs.sv
// Directed bench for apb3_completer_regs; expected latency follows
// APB3_COMPLETER_WAIT_EN (2 wait states when defined, 0 otherwise).
module tb_apb3_completer_regs;
`ifdef APB3_COMPLETER_WAIT_EN
    localparam int EXP_W = 2;
`else
    localparam int EXP_W = 0;
`endif
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    int         cyc;

    renode_apb3_if apb ();

    apb3_completer_regs #(
        .AddressWidth(20),
        .DataWidth   (32),
        .RegCount    (16),
        .ResetValue  (32'h0),
        .WaitCycles  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .apb3     (apb),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Caller is positioned 1 time unit after a rising edge; returns likewise.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        apb.paddr   = addr;
        apb.pwrite  = wr;
        apb.pwdata  = wdata;
        apb.pselx   = 1'b1;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        waits = 0;
        while (apb.pready !== 1'b1 && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 40) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h: pready=%b required 1", addr, apb.pready);
        end
        rdata = apb.prdata;
        err   = apb.pslverr;
        @(posedge clk); #1;
        apb.pselx   = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        int          w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (apb.pready !== 1'b0)  begin errors++; $display("FAIL reset_pready: got %b want 0", apb.pready); end
        if (apb.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", apb.pslverr); end
        if (apb.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", apb.prdata); end
        if (apb.presetn !== 1'b0) begin errors++; $display("FAIL reset_presetn: got %b want 0", apb.presetn); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        checks++;
        if (apb.presetn !== 1'b0) begin errors++; $display("FAIL presetn_release_cycle: got %b want 0", apb.presetn); end
        @(posedge clk); #1;
        checks++;
        if (apb.presetn !== 1'b1) begin errors++; $display("FAIL presetn_after: got %b want 1", apb.presetn); end
        apb_xfer(1'b0, 32'h14, 32'h0, rd, er, w);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_idx5: got %h want 00000000", rd); end
        if (er !== 1'b0)  begin errors++; $display("FAIL reset_read_err: got %b want 0", er); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        int          w;
        apb_xfer(1'b1, 32'h14, 32'hDEAD_BEEF, rd, er, w);
        checks += 2;
        if (er !== 1'b0) begin errors++; $display("FAIL wr14_err: got %b want 0", er); end
        if (w != EXP_W)  begin errors++; $display("FAIL wr14_waits: got %0d want %0d", w, EXP_W); end
        apb_xfer(1'b0, 32'h14, 32'h0, rd, er, w);
        checks += 3;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd14_data: got %h want deadbeef", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL rd14_err: got %b want 0", er); end
        if (w != EXP_W)  begin errors++; $display("FAIL rd14_waits: got %0d want %0d", w, EXP_W); end
        // Highest legal index, and an alias above the decoded address width.
        apb_xfer(1'b1, 32'h3C, 32'hCAFE_F00D, rd, er, w);
        apb_xfer(1'b0, 32'h3C, 32'h0, rd, er, w);
        checks += 2;
        if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd3c_data: got %h want cafef00d", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL rd3c_err: got %b want 0", er); end
        apb_xfer(1'b0, 32'h0010_0014, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_upper_bits: got %h want deadbeef", rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        er;
        int          w;
        apb_xfer(1'b0, 32'h41, 32'h0, rd, er, w);
        checks += 2;
        if (er !== 1'b1)   begin errors++; $display("FAIL err_misaligned_pslverr: got %b want 1", er); end
        if (rd !== 32'h0)  begin errors++; $display("FAIL err_misaligned_prdata: got %h want 0", rd); end
        apb_xfer(1'b1, 32'h40, 32'h1, rd, er, w);
        checks += 2;
        if (er !== 1'b1)   begin errors++; $display("FAIL err_range_pslverr: got %b want 1", er); end
        if (rd !== 32'h0)  begin errors++; $display("FAIL err_range_prdata: got %h want 0", rd); end
        apb_xfer(1'b1, 32'h15, 32'h5555_5555, rd, er, w);
        checks++;
        if (er !== 1'b1)   begin errors++; $display("FAIL err_mis_write_pslverr: got %b want 1", er); end
        apb_xfer(1'b0, 32'h0, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0)  begin errors++; $display("FAIL err_reg0_unchanged: got %h want 0", rd); end
        apb_xfer(1'b0, 32'h14, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_reg5_unchanged: got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          w1;
        int          w2;
        int          c0;
        c0 = cyc;
        apb_xfer(1'b1, 32'h0, 32'h1111_1111, rd, er, w1);
        apb_xfer(1'b0, 32'h0, 32'h0, rd, er, w2);
        checks += 4;
        if (rd !== 32'h1111_1111) begin errors++; $display("FAIL b2b_data: got %h want 11111111", rd); end
        if (w1 != EXP_W) begin errors++; $display("FAIL b2b_wr_waits: got %0d want %0d", w1, EXP_W); end
        if (w2 != EXP_W) begin errors++; $display("FAIL b2b_rd_waits: got %0d want %0d", w2, EXP_W); end
        if (cyc - c0 != 2 * (EXP_W + 2)) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d want %0d", cyc - c0, 2 * (EXP_W + 2));
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        er;
        int          w;
        apb.paddr   = 32'h8;
        apb.pwrite  = 1'b1;
        apb.pwdata  = 32'hA5A5_A5A5;
        apb.pselx   = 1'b1;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.pselx = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
        if (apb.pready !== 1'b0)   begin errors++; $display("FAIL abort_pready: got %b want 0", apb.pready); end
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL abort_reg8: got %h want 0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          w;
        apb.paddr   = 32'h3C;
        apb.pwrite  = 1'b1;
        apb.pwdata  = 32'h1234_5678;
        apb.pselx   = 1'b1;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        w = 0;
        while (apb.pready !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks += 3;
        if (apb.pready !== 1'b0)   begin errors++; $display("FAIL midrst_pready: got %b want 0", apb.pready); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
        if (apb.presetn !== 1'b0)  begin errors++; $display("FAIL midrst_presetn: got %b want 0", apb.presetn); end
        rst = 1'b0;
        apb.pselx   = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h3C, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_reg15: got %h want 0", rd); end
        apb_xfer(1'b0, 32'h14, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_reg5: got %h want 0", rd); end
    endtask

    task automatic test_protocol();
        logic [31:0] rd;
        logic        er;
        int          w;
        apb.paddr   = 32'h4;
        apb.pwrite  = 1'b1;
        apb.pwdata  = 32'h7777_7777;
        apb.pselx   = 1'b1;
        apb.penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (apb.pready !== 1'b0)   begin errors++; $display("FAIL proto_pready[%0d]: got %b want 0", i, apb.pready); end
            if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL proto_state[%0d]: got %0d want 0", i, dbg_state); end
        end
        apb.pselx   = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL proto_reg1: got %h want 0", rd); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        apb.paddr   = 32'h0;
        apb.pselx   = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.pwdata  = 32'h0;
        test_reset();
        test_write_read();
        test_error();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
